// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and the datapath: instruction fields and status in, enables and selects out.
interface multicycle_ctrl_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] imm_src;
    logic       reg_write;
    logic [2:0] alu_control;
    logic       instr_retired;
    logic       illegal_instr;

    // Controller side
    modport master (
        input  op, funct3, funct7_5, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
               alu_src_b, imm_src, reg_write, alu_control, instr_retired, illegal_instr
    );

    // Datapath side
    modport slave (
        output op, funct3, funct7_5, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
               alu_src_b, imm_src, reg_write, alu_control, instr_retired, illegal_instr
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core; Moore outputs plus the ALU decoder.
// Stalls in FETCH / MEMREAD / MEMWRITE until mem_ready; all outputs forced low while rst_n is low.
module multicycle_ctrl #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_t state_q, state_d;

    logic       pc_update, branch;
    logic [1:0] alu_op;
    logic [2:0] alu_ctl;
    logic       adr_src, mem_write, ir_write, reg_write, retired, illegal;
    logic [1:0] result_src, src_a, src_b;
    logic [2:0] imm_src;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= state_t'(RESET_STATE);
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (bus.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (bus.mem_ready) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
    end

    // Output decode
    always_comb begin
        pc_update  = 1'b0;
        branch     = 1'b0;
        alu_op     = 2'b00;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        retired    = 1'b0;
        illegal    = 1'b0;
        result_src = 2'b00;
        src_a      = 2'b00;
        src_b      = 2'b00;
        imm_src    = 3'b000;
        case (state_q)
            S_FETCH: begin
                src_b      = 2'b10;
                result_src = 2'b10;
                ir_write   = bus.mem_ready;
                pc_update  = bus.mem_ready;
            end
            S_DECODE: begin
                src_a   = 2'b01;
                src_b   = 2'b01;
                imm_src = 3'b010;
            end
            S_MEMADR: begin
                src_a   = 2'b10;
                src_b   = 2'b01;
                imm_src = (bus.op == OP_STORE) ? 3'b001 : 3'b000;
            end
            S_MEMREAD: adr_src = 1'b1;
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                retired    = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                retired   = bus.mem_ready;
            end
            S_EXECR: begin
                src_a  = 2'b10;
                alu_op = 2'b10;
            end
            S_EXECI: begin
                src_a  = 2'b10;
                src_b  = 2'b01;
                alu_op = 2'b10;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                retired   = 1'b1;
            end
            S_BRANCH: begin
                src_a   = 2'b10;
                alu_op  = 2'b01;
                branch  = 1'b1;
                retired = 1'b1;
            end
            S_JAL: begin
                src_a     = 2'b01;
                src_b     = 2'b10;
                pc_update = 1'b1;
            end
            S_TRAP:  illegal = 1'b1;
            default: ;
        endcase
    end

    // ALU decoder; only R-type funct3=000 with IR[30] set selects subtract
    always_comb begin
        alu_ctl = 3'b000;
        case (alu_op)
            2'b01: alu_ctl = 3'b101;
            2'b10: begin
                case (bus.funct3)
                    3'b000:  alu_ctl = (bus.op == OP_RTYPE && bus.funct7_5) ? 3'b001 : 3'b000;
                    3'b001:  alu_ctl = 3'b110;
                    3'b010:  alu_ctl = 3'b101;
                    3'b011:  alu_ctl = 3'b101;
                    3'b100:  alu_ctl = 3'b100;
                    3'b101:  alu_ctl = 3'b110;
                    3'b110:  alu_ctl = 3'b011;
                    default: alu_ctl = 3'b010;
                endcase
            end
            default: alu_ctl = 3'b000;
        endcase
    end

    // The FETCH state's Moore selects are non-zero, so reset gates every output directly
    assign bus.pc_write      = rst_n & (pc_update | (branch & bus.zero));
    assign bus.adr_src       = rst_n & adr_src;
    assign bus.mem_write     = rst_n & mem_write;
    assign bus.ir_write      = rst_n & ir_write;
    assign bus.reg_write     = rst_n & reg_write;
    assign bus.instr_retired = rst_n & retired;
    assign bus.illegal_instr = rst_n & illegal;
    assign bus.result_src    = rst_n ? result_src : 2'b00;
    assign bus.alu_src_a     = rst_n ? src_a      : 2'b00;
    assign bus.alu_src_b     = rst_n ? src_b      : 2'b00;
    assign bus.imm_src       = rst_n ? imm_src    : 3'b000;
    assign bus.alu_control   = rst_n ? alu_ctl    : 3'b000;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle RV32I core.
- Reuses one ALU (alu_top) across fetch, address generation, execute and branch compare, and sequences the PC, IR, memory and register-file enables around it.
- Contains the ALU decoder that produces the 3-bit ALUControl encoding and stalls on a memory ready handshake.

Parameters:
- RESET_STATE, 4'd0, state entered on reset (FETCH); kept at 0 in all builds.

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- op  in  7  instruction opcode (IR[6:0])
- funct3  in  3  IR[14:12]
- funct7_5  in  1  IR[30]
- zero  in  1  ALU Zero flag (Result[0]); 1 = compare condition true
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address: 0 = PC, 1 = Result
- mem_write  out  1  data memory write strobe
- ir_write  out  1  IR/OldPC load enable
- result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = RD1
- alu_src_b  out  2  00 = RD2, 01 = ImmExt, 10 = constant 4
- imm_src  out  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U
- reg_write  out  1  register-file write enable
- alu_control  out  3  ALU operation select
- instr_retired  out  1  one-cycle pulse when an instruction completes
- illegal_instr  out  1  sticky; high in state TRAP

Behaviour:
- State register is updated by async reset to FETCH. While rst_n = 0, every enable (pc_write, mem_write, ir_write, reg_write, instr_retired, illegal_instr) is 0 and every select output is 0.
- Outputs are Moore-decoded from state, except:
  - pc_write = pc_update | (branch & zero)
  - FETCH enables are qualified by mem_ready.
- ALUOp to alu_control mapping:
  - ALUOp 00 → 000 (add).
  - ALUOp 01 → 101 (compare; the comparator evaluates funct3 for beq/bne/blt/bge/bltu/bgeu).
  - ALUOp 10 → decode funct3:
    - 000: 001 (sub) if op = 0110011 and funct7_5 = 1, else 000.
    - 001 → 110.
    - 010 → 101.
    - 011 → 101.
    - 100 → 100.
    - 101 → 110; the shifter itself uses funct7_5 for arithmetic vs logical.
    - 110 → 011.
    - 111 → 010.
- States and transitions:
  - FETCH (0): adr_src = 0, alu_src_a = 00, alu_src_b = 10, ALUOp 00, result_src = 10. If mem_ready, assert ir_write = 1 and pc_update = 1, then go to DECODE; else stay in FETCH with all enables 0.
  - DECODE (1): alu_src_a = 01, alu_src_b = 01, imm_src = 010, ALUOp 00 (branch target into ALUOut). Next state by op:
    - 0000011 / 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - any other → TRAP
  - MEMADR (2): alu_src_a = 10, alu_src_b = 01, ALUOp 00. imm_src = 000 for loads, 001 for stores. Next: MEMREAD for loads, MEMWRITE for stores.
  - MEMREAD (3): adr_src = 1, result_src = 00. Wait for mem_ready, then go to MEMWB.
  - MEMWB (4): result_src = 01, reg_write = 1, instr_retired = 1. Next: FETCH.
  - MEMWRITE (5): adr_src = 1, result_src = 00. mem_write = 1 every cycle in this state. Leave to FETCH on mem_ready, asserting instr_retired in that cycle.
  - EXECR (6): alu_src_a = 10, alu_src_b = 00, ALUOp 10. Next: ALUWB.
  - EXECI (7): alu_src_a = 10, alu_src_b = 01, imm_src = 000, ALUOp 10. Next: ALUWB.
  - ALUWB (8): result_src = 00, reg_write = 1, instr_retired = 1. Next: FETCH.
  - BRANCH (9): alu_src_a = 10, alu_src_b = 00, ALUOp 01, result_src = 00, branch = 1, instr_retired = 1. Next: FETCH.
  - JAL (10): alu_src_a = 01, alu_src_b = 10, ALUOp 00, result_src = 00, pc_update = 1. Next: ALUWB (the ALUWB pulse retires it).
  - TRAP (11): illegal_instr = 1, all enables 0. Stays in TRAP until reset.
  - Encodings 12–15: decode to all-zero outputs, next state FETCH.
- CPI by class: load 5, store 4, R/I 4, branch 3, jal 4 (plus stall cycles).
- mem_ready low in FETCH, MEMREAD or MEMWRITE holds state indefinitely with outputs stable.
- Reset asserted in any state, including mid-stall, forces FETCH immediately with all enables 0. On release, the first edge evaluates FETCH.

Test Plan:
- Reset, then add x3,x1,x2 (op 0110011, f3 000, f7_5 0), mem_ready = 1 → states 0,1,6,8; alu_control 000 in EXECR; reg_write = 1 only in ALUWB; instr_retired pulses once; 4 cycles.
- sub (f7_5 = 1) then addi with IR[30] = 1 → alu_control 001 in EXECR, 000 in EXECI.
- beq with zero = 1, then zero = 0 → BRANCH alu_control 101; pc_write = 1 only when zero = 1; back to FETCH after 3 cycles either way.
- lw, mem_ready low 2 cycles in FETCH and 3 cycles in MEMREAD → ir_write is a single pulse; total 10 cycles; reg_write with result_src 01 in MEMWB.
- sw with mem_ready low 1 cycle → mem_write high both MEMWRITE cycles, reg_write never 1; op 1111111 → TRAP, illegal_instr = 1 sticky, enables 0.
- rst_n low during MEMREAD stall → all outputs 0 asynchronously; after release, FETCH with adr_src 0, alu_src_b 10.
